pointwise_mac_1x1: RTL

Pointwise (1x1) convolution arithmetic stage that consumes the 32-bit pixel stream delivered by the 1x1/stride-1 kernel window stage. For each pixel it multiplies CHANNELS consecutive input words by a per-channel weight and sums the products. It then adds a bias, saturates the result and emits one 32-bit output word per pixel. It sits directly downstream of the 1x1 window stage and upstream of the next layer's window/line buffer.

---
 rtl/pointwise_mac_1x1_pkg.sv | 25 ++
 rtl/pointwise_mac_1x1_mul.sv | 33 +++
 rtl/pointwise_mac_1x1.sv | 106 ++++++++++
 3 files changed

// File: rtl/pointwise_mac_1x1_pkg.sv
// Shared fixed-point types and constants for the pointwise (1x1) convolution stages.
// Also provides the 56-bit to 32-bit signed saturation helper.
package pointwise_mac_1x1_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 56;

  localparam logic signed [ACC_W-1:0] SAT_HI = 56'sh00_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_LO = 56'shFF_FFFF_8000_0000;

  typedef logic signed [DATA_W-1:0] fxp_word_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } stage_flags_t;

  function automatic fxp_word_t sat_fxp(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return fxp_word_t'(32'h7FFF_FFFF);
    else if (v < SAT_LO) return fxp_word_t'(32'h8000_0000);
    else                 return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/pointwise_mac_1x1_mul.sv
// Stage 1: signed 32x32 multiply, arithmetic shift by FRAC_BITS, registered
// together with the channel flags of the word that produced it.
module fxp_mul_shift
  import pointwise_mac_1x1_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  stage_flags_t            in_flags,
  input  fxp_word_t               a,
  input  fxp_word_t               b,
  output stage_flags_t            out_flags,
  output logic signed [ACC_W-1:0] prod
);

  logic signed [2*DATA_W-1:0] full;

  assign full = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  always_ff @(posedge clk) begin
    if (rst) out_flags <= '0;
    else     out_flags <= in_flags;
  end

  // The shifted product carries at most 64-FRAC_BITS significant bits, so
  // keeping the low ACC_W bits is lossless for FRAC_BITS >= 8.
  always_ff @(posedge clk) begin
    if (rst)              prod <= '0;
    else if (in_flags.vld) prod <= ACC_W'(full >>> FRAC_BITS);
  end

endmodule

// File: rtl/pointwise_mac_1x1.sv
// Pointwise 1x1 MAC: per-pixel dot product of CHANNELS words with weights, plus bias,
// saturated to 32 bits. Define POINTWISE_RELU_EN to clamp negative results to zero.
module pointwise_mac_1x1
  import pointwise_mac_1x1_pkg::*;
#(
  parameter int IMG_WIDHT  = 299,
  parameter int IMG_HEIGHT = 299,
  parameter int CHANNELS   = 4,
  parameter int FRAC_BITS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  input  logic              W_We,
  input  logic [7:0]        W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              B_We,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Valid_Out,
  output logic              Frame_Done
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PIX_N = IMG_WIDHT * IMG_HEIGHT;
  localparam int PW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;

  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(PIX_N - 1);

  // Configuration state: deliberately outside reset.
  fxp_word_t weight [CHANNELS];
  fxp_word_t bias;

  always_ff @(posedge clk) begin
    if (W_We && (int'(W_Addr) < CHANNELS)) weight[W_Addr[CW-1:0]] <= W_Data;
    if (B_We) bias <= W_Data;
  end

  logic [CW-1:0] ch;

  always_ff @(posedge clk) begin
    if (rst)           ch <= '0;
    else if (Valid_In) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
  end

  stage_flags_t            s0_flags, s1_flags;
  logic signed [ACC_W-1:0] s1_prod;

  assign s0_flags = '{vld: Valid_In, first: (ch == '0), last: (ch == CH_LAST)};

  fxp_mul_shift #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_flags  (s0_flags),
    .a         (fxp_word_t'(Data_In)),
    .b         (weight[ch]),
    .out_flags (s1_flags),
    .prod      (s1_prod)
  );

  // Stage 2: first channel loads, so the next pixel overlaps the output stage.
  logic signed [ACC_W-1:0] acc;
  logic                    s2_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      s2_done <= 1'b0;
    end else begin
      s2_done <= s1_flags.vld & s1_flags.last;
      if (s1_flags.vld) acc <= s1_flags.first ? s1_prod : acc + s1_prod;
    end
  end

  logic signed [ACC_W-1:0] sum;
  fxp_word_t               sat, res;

  assign sum = acc + ACC_W'(bias);
  assign sat = sat_fxp(sum);

`ifdef POINTWISE_RELU_EN
  assign res = sat[DATA_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  logic [PW-1:0] pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      Data_Out   <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      pix        <= '0;
    end else begin
      Valid_Out  <= s2_done;
      Frame_Done <= s2_done && (pix == PIX_MAX);
      if (s2_done) begin
        Data_Out <= res;
        pix      <= (pix == PIX_MAX) ? '0 : pix + 1'b1;
      end
    end
  end

endmodule
